// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: RISC-V funct3 load/store encodings
// and the controller state enum.
package dmem_pkg;

    // funct3 access types; stores reuse the low two bits (00 byte, 01 half, 10 word)
    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;

    typedef enum logic [1:0] {
        INIT,
        CLEAR,
        RUN
    } dmem_state_e;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic for the data memory: load byte/half extraction with
// sign or zero extension, store byte-lane merge into the current word, and
// misalignment / invalid-op detection.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [2:0]    op,
    input  logic [1:0]    byte_off,
    input  logic [DW-1:0] word,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] load_data,
    output logic [DW-1:0] store_word,
    output logic          misalign,
    output logic          invalid
);

    localparam int unsigned NB = DW / 8;

    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [NB-1:0] be;
    logic [DW-1:0] sdata;

    // Lane selection shared by loads and stores
    always_comb begin
        byte_sel = word[{byte_off, 3'b000} +: 8];
        half_sel = word[{byte_off[1], 4'b0000} +: 16];
    end

    // Access checks: funct3 011/110/111 are not loads, size vs. low address bits
    always_comb begin
        invalid  = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
        misalign = 1'b0;
        case (op[1:0])
            2'b01:   misalign = byte_off[0];
            2'b10:   misalign = (byte_off != 2'b00);
            default: misalign = 1'b0;
        endcase
    end

    // Load extension by access type
    always_comb begin
        load_data = '0;
        case (op)
            MEM_LB:  load_data = {{(DW-8){byte_sel[7]}}, byte_sel};
            MEM_LH:  load_data = {{(DW-16){half_sel[15]}}, half_sel};
            MEM_LW:  load_data = word;
            MEM_LBU: load_data = {{(DW-8){1'b0}}, byte_sel};
            MEM_LHU: load_data = {{(DW-16){1'b0}}, half_sel};
            default: load_data = '0;
        endcase
    end

    // Store: replicate the narrow datum across lanes, enable only the addressed ones
    always_comb begin
        be    = '0;
        sdata = wdata;
        case (op[1:0])
            2'b00: begin
                be    = NB'(1) << byte_off;
                sdata = {NB{wdata[7:0]}};
            end
            2'b01: begin
                be    = NB'(3) << {byte_off[1], 1'b0};
                sdata = {(NB/2){wdata[15:0]}};
            end
            default: begin
                be    = '1;
                sdata = wdata;
            end
        endcase
        store_word = word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                store_word[8*i +: 8] = sdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with RISC-V byte/half/word loads and stores,
// registered load data, one-cycle error pulse for misaligned or invalid accesses.
// Optional feature: define DMEM_CLEAR_ON_RESET_EN to zero all words after reset
// (ready then rises DEPTH+1 edges after release instead of one).
module data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic [2:0]    op,
    input  logic          we,
    input  logic          re,
    output logic [DW-1:0] rdata,
    output logic          ready,
    output logic          err
);

    localparam int unsigned IW = $clog2(DEPTH);

    dmem_state_e   state_q;
    logic          ready_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;

    logic [DW-1:0] mem [DEPTH];

    logic [IW-1:0] idx;
    logic [DW-1:0] cur_word;
    logic [DW-1:0] load_data;
    logic [DW-1:0] store_word;
    logic          misalign;
    logic          invalid;
    logic          run;
    logic          bad;
    logic          do_write;
    logic          do_read;

    logic          mem_we;
    logic [IW-1:0] mem_widx;
    logic [DW-1:0] mem_wword;

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);
    logic [IW-1:0] clr_cnt_q;
`endif

    // Upper address bits are ignored so the address space wraps onto DEPTH words
    assign idx      = addr[IW+1:2];
    assign cur_word = mem[idx];

    if (AW > IW + 2) begin : g_unused_addr
        logic unused_addr_bits;
        assign unused_addr_bits = ^addr[AW-1:IW+2];
    end

    dmem_align #(
        .DW(DW)
    ) u_align (
        .op        (op),
        .byte_off  (addr[1:0]),
        .word      (cur_word),
        .wdata     (wdata),
        .load_data (load_data),
        .store_word(store_word),
        .misalign  (misalign),
        .invalid   (invalid)
    );

    // Accesses only count in RUN; a rejected one neither writes nor reads
    always_comb begin
        run      = (state_q == RUN);
        bad      = run && (we || re) && (misalign || invalid);
        do_write = run && we && !bad;
        do_read  = run && re && !bad;
    end

    // Single memory write port shared by CPU stores and the clear sweep
    always_comb begin
        mem_we    = do_write;
        mem_widx  = idx;
        mem_wword = store_word;
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_widx  = clr_cnt_q;
            mem_wword = '0;
        end
`endif
    end

    // Memory array; contents are not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wword;
        end
    end

    // Controller: INIT -> (CLEAR sweep) -> RUN, ready registered alongside state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= INIT;
            ready_q   <= 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                INIT: begin
`ifdef DMEM_CLEAR_ON_RESET_EN
                    state_q   <= CLEAR;
                    clr_cnt_q <= '0;
`else
                    state_q   <= RUN;
                    ready_q   <= 1'b1;
`endif
                end
                CLEAR: begin
`ifdef DMEM_CLEAR_ON_RESET_EN
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LastIdx) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
`else
                    state_q <= INIT;
`endif
                end
                RUN: begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Load result and error pulse; read-first since cur_word is the pre-edge value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= bad;
            if (bad) begin
                rdata_q <= '0;
            end else if (do_read) begin
                rdata_q <= load_data;
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (DEPTH=16).
// Expectations follow DMEM_CLEAR_ON_RESET_EN when it is defined for the build.
module tb_data_memory;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  op = MEM_LW;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory #(
        .DW   (32),
        .AW   (32),
        .DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .wdata(wdata),
        .op   (op),
        .we   (we),
        .re   (re),
        .rdata(rdata),
        .ready(ready),
        .err  (err)
    );

    // Drive one access for one clock, then sample 1 time unit after the edge
    task automatic drive(input logic w, input logic r, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = w; re = r; op = o; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    // Expects rst already low; checks reset outputs, releases, and tracks ready
    task automatic reset_sequence();
        #2;
        if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got=%b want=0", ready); end
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata: got=%h want=0", rdata); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got=%b want=0", err); end
        checks++;
        @(negedge clk);
        rst = 1'b1;
        // access attempted while not ready must be ignored
        we = 1'b1; re = 1'b1; op = MEM_LW; addr = 32'h4; wdata = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0;
        if (rdata !== 32'h0) begin failures++; $display("FAIL notready_rdata: got=%h want=0", rdata); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL notready_err: got=%b want=0", err); end
        checks++;
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (ready !== 1'b0) begin failures++; $display("FAIL ready_edge1: got=%b want=0", ready); end
        checks++;
        for (int k = 2; k <= DEPTH; k++) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_low_edge%0d: got=%b want=0", k, ready);
            end
            checks++;
        end
        @(posedge clk);
        #1;
        if (ready !== 1'b1) begin failures++; $display("FAIL ready_rise: got=%b want=1", ready); end
        checks++;
`else
        if (ready !== 1'b1) begin failures++; $display("FAIL ready_rise: got=%b want=1", ready); end
        checks++;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        reset_sequence();
    endtask

    task automatic test_clear_zero();
`ifndef DMEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < int'(DEPTH); i++) drive(1'b1, 1'b0, MEM_LW, 32'(i * 4), 32'h0);
`endif
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b0, 1'b1, MEM_LW, 32'(i * 4), 32'h0);
            if (rdata !== 32'h0 || err !== 1'b0) begin
                failures++;
                $display("FAIL zero_word%0d: rdata=%h err=%b want=0/0", i, rdata, err);
            end
            checks++;
        end
    endtask

    task automatic test_loads();
        logic [2:0]  t_op  [8] = '{MEM_LB, MEM_LB, MEM_LBU, MEM_LHU, MEM_LH,
                                   MEM_LW, MEM_LH, MEM_LHU};
        logic [31:0] t_adr [8] = '{32'h8, 32'hA, 32'hB, 32'hA, 32'hA, 32'h8, 32'h8, 32'h8};
        logic [31:0] t_exp [8] = '{32'h0000005A, 32'hFFFFFFF0, 32'h00000080, 32'h000080F0,
                                   32'hFFFF80F0, 32'h80F0A55A, 32'hFFFFA55A, 32'h0000A55A};
        drive(1'b1, 1'b0, MEM_LW, 32'h8, 32'h80F0A55A);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, t_op[i], t_adr[i], 32'h0);
            if (rdata !== t_exp[i] || err !== 1'b0) begin
                failures++;
                $display("FAIL load%0d op=%b addr=%h: rdata=%h err=%b want=%h/0",
                         i, t_op[i], t_adr[i], rdata, err, t_exp[i]);
            end
            checks++;
        end
    endtask

    task automatic test_store_merge();
        drive(1'b1, 1'b0, MEM_LB, 32'h9, 32'hDEADBE11);
        drive(1'b0, 1'b1, MEM_LW, 32'h8, 32'h0);
        if (rdata !== 32'h80F0115A) begin failures++; $display("FAIL sb_merge: got=%h want=80f0115a", rdata); end
        checks++;
        drive(1'b1, 1'b0, MEM_LH, 32'hE, 32'h1234BEEF);
        drive(1'b0, 1'b1, MEM_LW, 32'hC, 32'h0);
        if (rdata !== 32'hBEEF0000) begin failures++; $display("FAIL sh_merge: got=%h want=beef0000", rdata); end
        checks++;
        drive(1'b0, 1'b1, MEM_LH, 32'hE, 32'h0);
        if (rdata !== 32'hFFFFBEEF) begin failures++; $display("FAIL lh_hi: got=%h want=ffffbeef", rdata); end
        checks++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, MEM_LW, 32'h8, 32'h0);
        if (rdata !== 32'h80F0115A) begin failures++; $display("FAIL read_first: got=%h want=80f0115a", rdata); end
        checks++;
        drive(1'b0, 1'b1, MEM_LW, 32'h8, 32'h0);
        if (rdata !== 32'h0) begin failures++; $display("FAIL after_write: got=%h want=0", rdata); end
        checks++;
        drive(1'b0, 1'b1, MEM_LBU, 32'hF, 32'h0);
        drive(1'b0, 1'b0, MEM_LW, 32'h0, 32'h0);
        if (rdata !== 32'h000000BE) begin failures++; $display("FAIL hold_idle: got=%h want=be", rdata); end
        checks++;
        drive(1'b1, 1'b0, MEM_LW, 32'h20, 32'h77777777);
        if (rdata !== 32'h000000BE) begin failures++; $display("FAIL hold_write: got=%h want=be", rdata); end
        checks++;
    endtask

    task automatic test_errors();
        drive(1'b1, 1'b0, MEM_LW, 32'h4, 32'hA5A5A5A5);
        drive(1'b0, 1'b1, MEM_LW, 32'h4, 32'h0);
        if (rdata !== 32'hA5A5A5A5 || err !== 1'b0) begin
            failures++; $display("FAIL err_pre: rdata=%h err=%b want=a5a5a5a5/0", rdata, err);
        end
        checks++;
        drive(1'b0, 1'b1, MEM_LW, 32'h6, 32'h0);
        if (rdata !== 32'h0 || err !== 1'b1) begin
            failures++; $display("FAIL lw_misalign: rdata=%h err=%b want=0/1", rdata, err);
        end
        checks++;
        drive(1'b0, 1'b0, MEM_LW, 32'h0, 32'h0);
        if (err !== 1'b0) begin failures++; $display("FAIL err_pulse1: got=%b want=0", err); end
        checks++;
        drive(1'b0, 1'b1, MEM_LW, 32'h4, 32'h0);
        drive(1'b1, 1'b0, MEM_LH, 32'h5, 32'h00007777);
        if (rdata !== 32'h0 || err !== 1'b1) begin
            failures++; $display("FAIL sh_misalign: rdata=%h err=%b want=0/1", rdata, err);
        end
        checks++;
        drive(1'b0, 1'b0, MEM_LW, 32'h0, 32'h0);
        if (err !== 1'b0) begin failures++; $display("FAIL err_pulse2: got=%b want=0", err); end
        checks++;
        drive(1'b0, 1'b1, 3'b111, 32'h4, 32'h0);
        if (rdata !== 32'h0 || err !== 1'b1) begin
            failures++; $display("FAIL op111: rdata=%h err=%b want=0/1", rdata, err);
        end
        checks++;
        drive(1'b1, 1'b0, 3'b011, 32'h4, 32'hFFFFFFFF);
        if (err !== 1'b1) begin failures++; $display("FAIL op011: err=%b want=1", err); end
        checks++;
        drive(1'b0, 1'b1, MEM_LW, 32'h4, 32'h0);
        if (rdata !== 32'hA5A5A5A5 || err !== 1'b0) begin
            failures++; $display("FAIL err_no_write: rdata=%h err=%b want=a5a5a5a5/0", rdata, err);
        end
        checks++;
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, MEM_LW, 32'h4 + 32'(4 * DEPTH), 32'h0);
        if (rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL wrap_read: got=%h want=a5a5a5a5", rdata); end
        checks++;
        drive(1'b1, 1'b0, MEM_LW, 32'h4 + 32'(8 * DEPTH), 32'h12345678);
        drive(1'b0, 1'b1, MEM_LW, 32'h4, 32'h0);
        if (rdata !== 32'h12345678) begin failures++; $display("FAIL wrap_write: got=%h want=12345678", rdata); end
        checks++;
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
        logic [31:0] exp_w15;
        drive(1'b1, 1'b0, MEM_LW, 32'h0, 32'hFFFFFFFF);
        drive(1'b1, 1'b0, MEM_LW, 32'h3C, 32'h13579BDF);
        drive(1'b0, 1'b0, MEM_LW, 32'h0, 32'h0);
`ifdef DMEM_CLEAR_ON_RESET_EN
        exp_w0 = 32'h0; exp_w1 = 32'h0; exp_w15 = 32'h0;
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        if (ready !== 1'b0) begin failures++; $display("FAIL mid_clear_ready: got=%b want=0", ready); end
        checks++;
        rst = 1'b0;
`else
        exp_w0 = 32'hFFFFFFFF; exp_w1 = 32'h12345678; exp_w15 = 32'h13579BDF;
        #1;
        rst = 1'b0;
`endif
        reset_sequence();
        drive(1'b0, 1'b1, MEM_LW, 32'h0, 32'h0);
        if (rdata !== exp_w0) begin failures++; $display("FAIL post_rst_w0: got=%h want=%h", rdata, exp_w0); end
        checks++;
        drive(1'b0, 1'b1, MEM_LW, 32'h4, 32'h0);
        if (rdata !== exp_w1) begin failures++; $display("FAIL post_rst_w1: got=%h want=%h", rdata, exp_w1); end
        checks++;
        drive(1'b0, 1'b1, MEM_LW, 32'h4 + 32'(4 * DEPTH), 32'h0);
        if (rdata !== exp_w1) begin failures++; $display("FAIL post_rst_wrap: got=%h want=%h", rdata, exp_w1); end
        checks++;
        drive(1'b0, 1'b1, MEM_LW, 32'h3C, 32'h0);
        if (rdata !== exp_w15) begin failures++; $display("FAIL post_rst_w15: got=%h want=%h", rdata, exp_w15); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_clear_zero();
        test_loads();
        test_store_merge();
        test_back_to_back();
        test_errors();
        test_wrap();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have a parameter DW, default 32, giving the data width in bits.
REQ-002 The block SHALL have a parameter AW, default 32, giving the byte address width.
REQ-003 The block SHALL have a parameter DEPTH, default 1024, giving the number of words; it is a power of two.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port addr, input, AW bits: byte address from the CPU.
REQ-007 The block SHALL have port wdata, input, DW bits: store data.
REQ-008 The block SHALL have port op, input, 3 bits: RISC-V funct3 access type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
REQ-009 The block SHALL have port we, input, 1 bit: write request.
REQ-010 The block SHALL have port re, input, 1 bit: read request.
REQ-011 The block SHALL have port rdata, output, DW bits: registered load result.
REQ-012 The block SHALL have port ready, output, 1 bit: high once the memory accepts accesses.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse for a rejected access.

Function
REQ-014 The word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap.
REQ-015 The state machine SHALL have three states, INIT, CLEAR and RUN; ready SHALL equal (state==RUN) and be driven from a register.
REQ-016 From INIT, the state SHALL go to CLEAR on the first edge after reset release when the macro is defined, or to RUN otherwise.
REQ-017 In CLEAR, a counter SHALL write zero to word 0..DEPTH-1, one word per cycle, then go to RUN; in total ready rises DEPTH+1 edges after release.
REQ-018 In RUN, when we=1, the store SHALL take effect at the edge: sb writes lane addr[1:0] with wdata[7:0]; sh writes half addr[1] with wdata[15:0]; sw writes the whole word; other lanes are unchanged.
REQ-019 In RUN, when re=1, rdata SHALL update at the edge (latency 1 cycle): lb/lh sign-extend, lbu/lhu zero-extend, lw takes the full word, using the same lane selection as stores.
REQ-020 When re=0, rdata SHALL hold its previous value.
REQ-021 When we=1 and re=1 target the same word in the same cycle, rdata SHALL return the pre-write contents (read-first), and the write SHALL still occur.
REQ-022 A misaligned access (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) SHALL suppress the write, load rdata=0, and pulse err for one cycle.
REQ-023 An invalid op (011, 110, 111) with we or re high SHALL suppress the write, load rdata=0, and pulse err for one cycle.
REQ-024 we or re asserted while ready=0 SHALL be ignored: no write, rdata held, no err.

Reset
REQ-025 When rst=0, the block SHALL asynchronously force state=INIT, the clear counter to 0, rdata=0, ready=0 and err=0.
REQ-026 Reset asserted during CLEAR SHALL restart the clear from word 0 after release.
REQ-027 Memory contents SHALL NOT be reset except by the CLEAR sequence.

Configuration
REQ-028 When DMEM_CLEAR_ON_RESET_EN is defined, the block SHALL include the CLEAR state and its counter; memory reads 0 everywhere after ready rises.
REQ-029 When DMEM_CLEAR_ON_RESET_EN is undefined, CLEAR and its counter SHALL be absent, ready SHALL rise one edge after release, and contents SHALL be unspecified until written.

Structure
REQ-030 Shared package dmem_pkg SHALL hold the op encodings (MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU) and the state enum {INIT, CLEAR, RUN}.
REQ-031 Sub-module dmem_align SHALL be combinational and provide load lane extraction/extension, store byte-enable/data merge, and misalign/invalid detection.

Verification
REQ-032 Macro defined, DEPTH=16, reset released: ready=0 for 16 cycles then 1; lw from every word returns 0x00000000.
REQ-033 sw 0x80F0A55A @0x8; then lb @0x8 -> 0x0000005A; lb @0xA -> 0xFFFFFFF0; lbu @0xB -> 0x00000080; lhu @0xA -> 0x000080F0; lh @0xA -> 0xFFFF80F0.
REQ-034 sb 0x11 @0x9 over 0x80F0A55A -> lw @0x8 returns 0x80F0115A; same-cycle sw 0x0 with lw @0x8 -> rdata=0x80F0115A, next lw -> 0x0.
REQ-035 lw @0x6 and sh @0x5 -> err high exactly one cycle each, rdata=0, memory unchanged; op=3'b111 with re=1 -> err pulse.
REQ-036 Reset pulsed at clear word 7 -> after release ready stays low a full DEPTH cycles; reads at 0x4 and 0x4+4*DEPTH return the same word.
